// File: rtl/y86_pkg.sv
// Shared Y86 encoding constants used by the fetch-side predictor.
package y86_pkg;

  localparam logic [3:0] ICODE_HALT   = 4'h0;
  localparam logic [3:0] ICODE_NOP    = 4'h1;
  localparam logic [3:0] ICODE_RRMOVQ = 4'h2;
  localparam logic [3:0] ICODE_IRMOVQ = 4'h3;
  localparam logic [3:0] ICODE_RMMOVQ = 4'h4;
  localparam logic [3:0] ICODE_MRMOVQ = 4'h5;
  localparam logic [3:0] ICODE_OPQ    = 4'h6;
  localparam logic [3:0] ICODE_JXX    = 4'h7;
  localparam logic [3:0] ICODE_CALL   = 4'h8;
  localparam logic [3:0] ICODE_RET    = 4'h9;
  localparam logic [3:0] ICODE_PUSHQ  = 4'hA;
  localparam logic [3:0] ICODE_POPQ   = 4'hB;

  localparam logic [3:0] JXX_UNCOND   = 4'h0;

endpackage

// File: rtl/y86_branch_predictor_if.sv
// Fetch / execute / back-end signals seen by the next-PC predictor.
// Handshake: inputs are sampled on every rising clock edge (no ready); f_valid qualifies
// the fetch group, e_bupd_valid the BHT update, redirect_valid the correction.
interface y86_branch_predictor_if #(
  parameter int ADDR_W    = 64,
  parameter int RAS_DEPTH = 8,
  parameter int CNT_W     = 32
);
  localparam int RC_W = $clog2(RAS_DEPTH) + 1;

  logic              f_valid;
  logic              f_stall;
  logic [ADDR_W-1:0] f_pc;
  logic [3:0]        f_icode;
  logic [3:0]        f_ifun;
  logic [ADDR_W-1:0] f_valC;
  logic [ADDR_W-1:0] f_valP;
  logic              e_bupd_valid;
  logic [ADDR_W-1:0] e_bupd_pc;
  logic              e_bupd_taken;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic [ADDR_W-1:0] pc_pred;
  logic              pred_taken;
  logic              ret_miss;
  logic [RC_W-1:0]   ras_count;
  logic [CNT_W-1:0]  mispredict_cnt;

  modport master (
    output f_valid, f_stall, f_pc, f_icode, f_ifun, f_valC, f_valP,
           e_bupd_valid, e_bupd_pc, e_bupd_taken, redirect_valid, redirect_pc,
    input  pc_pred, pred_taken, ret_miss, ras_count, mispredict_cnt
  );

  modport slave (
    input  f_valid, f_stall, f_pc, f_icode, f_ifun, f_valC, f_valP,
           e_bupd_valid, e_bupd_pc, e_bupd_taken, redirect_valid, redirect_pc,
    output pc_pred, pred_taken, ret_miss, ras_count, mispredict_cnt
  );

endinterface

// File: rtl/y86_ras.sv
// Circular return address stack: when full, a push overwrites the oldest entry.
module y86_ras #(
  parameter int RAS_DEPTH = 8,
  parameter int ADDR_W    = 64
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         clear,
  input  logic [ADDR_W-1:0]            push_data,
  output logic [ADDR_W-1:0]            top,
  output logic [$clog2(RAS_DEPTH):0]   count
);
  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int RC_W  = PTR_W + 1;

  logic [ADDR_W-1:0] mem_q [RAS_DEPTH];
  logic [ADDR_W-1:0] mem_d [RAS_DEPTH];
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [RC_W-1:0]   count_q, count_d;

  // ptr_q is the next free slot; the newest entry sits just below it (mod depth).
  always_comb begin
    for (int i = 0; i < RAS_DEPTH; i++) mem_d[i] = mem_q[i];
    ptr_d   = ptr_q;
    count_d = count_q;
    if (clear) begin
      ptr_d   = '0;
      count_d = '0;
    end else if (push) begin
      mem_d[ptr_q] = push_data;
      ptr_d        = ptr_q + 1'b1;
      if (count_q != RC_W'(RAS_DEPTH)) count_d = count_q + 1'b1;
    end else if (pop && (count_q != '0)) begin
      ptr_d   = ptr_q - 1'b1;
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr_q   <= '0;
      count_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < RAS_DEPTH; i++) mem_q[i] <= mem_d[i];
  end

  assign top   = mem_q[ptr_q - 1'b1];
  assign count = count_q;

endmodule

// File: rtl/y86_branch_predictor.sv
// Next-PC predictor: bimodal BHT for jXX, circular RAS for call/ret, back-end redirect.
module y86_branch_predictor
  import y86_pkg::*;
#(
  parameter int              ADDR_W    = 64,
  parameter int              BHT_DEPTH = 64,
  parameter int              RAS_DEPTH = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int              CNT_W     = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  y86_branch_predictor_if.slave  bus
);
  localparam int IDX_W = $clog2(BHT_DEPTH);
  localparam int RC_W  = $clog2(RAS_DEPTH) + 1;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              pred_taken_q, pred_taken_d;
  logic              ret_miss_q, ret_miss_d;
  logic [CNT_W-1:0]  mis_cnt_q, mis_cnt_d;
  logic [1:0]        bht_q [BHT_DEPTH];
  logic [1:0]        bht_d [BHT_DEPTH];

  logic              ras_push, ras_pop, ras_clear;
  logic [ADDR_W-1:0] ras_top;
  logic [RC_W-1:0]   ras_count;

  logic [IDX_W-1:0]  rd_idx, upd_idx;
  logic [1:0]        rd_cnt;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.f_pc[ADDR_W-1:IDX_W], bus.e_bupd_pc[ADDR_W-1:IDX_W]};

  assign rd_idx  = bus.f_pc[IDX_W-1:0];
  assign upd_idx = bus.e_bupd_pc[IDX_W-1:0];
  // Read from the registered array so a same-cycle update is not visible yet.
  assign rd_cnt  = bht_q[rd_idx];

  always_comb begin
    pc_d         = pc_q;
    pred_taken_d = pred_taken_q;
    ret_miss_d   = ret_miss_q;
    mis_cnt_d    = mis_cnt_q;
    ras_push     = 1'b0;
    ras_pop      = 1'b0;
    ras_clear    = 1'b0;
    if (bus.redirect_valid) begin
      pc_d         = bus.redirect_pc;
      pred_taken_d = 1'b0;
      ret_miss_d   = 1'b0;
      ras_clear    = 1'b1;
      if (mis_cnt_q != '1) mis_cnt_d = mis_cnt_q + CNT_W'(1);
    end else if (bus.f_stall) begin
      pc_d = pc_q;
    end else if (!bus.f_valid) begin
      pc_d         = bus.f_valP;
      pred_taken_d = 1'b0;
      ret_miss_d   = 1'b0;
    end else begin
      pc_d         = bus.f_valP;
      pred_taken_d = 1'b0;
      ret_miss_d   = 1'b0;
      case (bus.f_icode)
        ICODE_JXX: begin
          if ((bus.f_ifun == JXX_UNCOND) || rd_cnt[1]) begin
            pc_d         = bus.f_valC;
            pred_taken_d = 1'b1;
          end
        end
        ICODE_CALL: begin
          pc_d     = bus.f_valC;
          ras_push = 1'b1;
        end
        ICODE_RET: begin
          if (ras_count != '0) begin
            pc_d    = ras_top;
            ras_pop = 1'b1;
          end else begin
            ret_miss_d = 1'b1;
          end
        end
        default: pc_d = bus.f_valP;
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < BHT_DEPTH; i++) bht_d[i] = bht_q[i];
    if (bus.e_bupd_valid) begin
      if (bus.e_bupd_taken && (bht_q[upd_idx] != 2'b11))
        bht_d[upd_idx] = bht_q[upd_idx] + 2'b01;
      else if (!bus.e_bupd_taken && (bht_q[upd_idx] != 2'b00))
        bht_d[upd_idx] = bht_q[upd_idx] - 2'b01;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_q         <= RESET_PC;
      pred_taken_q <= 1'b0;
      ret_miss_q   <= 1'b0;
      mis_cnt_q    <= '0;
      for (int i = 0; i < BHT_DEPTH; i++) bht_q[i] <= 2'b01;
    end else begin
      pc_q         <= pc_d;
      pred_taken_q <= pred_taken_d;
      ret_miss_q   <= ret_miss_d;
      mis_cnt_q    <= mis_cnt_d;
      for (int i = 0; i < BHT_DEPTH; i++) bht_q[i] <= bht_d[i];
    end
  end

  y86_ras #(
    .RAS_DEPTH (RAS_DEPTH),
    .ADDR_W    (ADDR_W)
  ) u_ras (
    .clock     (clock),
    .reset     (reset),
    .push      (ras_push),
    .pop       (ras_pop),
    .clear     (ras_clear),
    .push_data (bus.f_valP),
    .top       (ras_top),
    .count     (ras_count)
  );

  assign bus.pc_pred        = pc_q;
  assign bus.pred_taken     = pred_taken_q;
  assign bus.ret_miss       = ret_miss_q;
  assign bus.ras_count      = ras_count;
  assign bus.mispredict_cnt = mis_cnt_q;

endmodule

// File: tb/tb_y86_branch_predictor.sv
// Bench for the next-PC predictor: directed scenarios plus random traffic against a queue/array model.
module tb_y86_branch_predictor;
  localparam int ADDR_W    = 32;
  localparam int BHT_DEPTH = 16;
  localparam int RAS_DEPTH = 8;
  localparam int CNT_W     = 4;
  localparam logic [ADDR_W-1:0] RESET_PC = '0;

  logic clock = 1'b0;
  logic reset = 1'b1;

  y86_branch_predictor_if #(.ADDR_W(ADDR_W), .RAS_DEPTH(RAS_DEPTH), .CNT_W(CNT_W)) bus ();

  y86_branch_predictor #(
    .ADDR_W(ADDR_W), .BHT_DEPTH(BHT_DEPTH), .RAS_DEPTH(RAS_DEPTH),
    .RESET_PC(RESET_PC), .CNT_W(CNT_W)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // clock / reset
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  int                bht_m [BHT_DEPTH];
  logic [ADDR_W-1:0] exp_q [$];
  logic [ADDR_W-1:0] exp_pc;
  logic              exp_pt, exp_rm, pt_known;
  int                exp_mis;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < BHT_DEPTH; i++) bht_m[i] = 1;
    exp_q.delete();
    exp_pc   = RESET_PC;
    exp_pt   = 1'b0;
    exp_rm   = 1'b0;
    pt_known = 1'b1;
    exp_mis  = 0;
  endtask

  task automatic idle();
    bus.f_valid        = 1'b0;
    bus.f_stall        = 1'b0;
    bus.f_pc           = '0;
    bus.f_icode        = 4'h1;
    bus.f_ifun         = 4'h0;
    bus.f_valC         = '0;
    bus.f_valP         = '0;
    bus.e_bupd_valid   = 1'b0;
    bus.e_bupd_pc      = '0;
    bus.e_bupd_taken   = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
  endtask

  task automatic fetch(input logic [3:0] icode, input logic [3:0] ifun, input int pc,
                       input int valc, input int valp);
    bus.f_valid = 1'b1;
    bus.f_stall = 1'b0;
    bus.f_icode = icode;
    bus.f_ifun  = ifun;
    bus.f_pc    = ADDR_W'(pc);
    bus.f_valC  = ADDR_W'(valc);
    bus.f_valP  = ADDR_W'(valp);
  endtask

  // Advance one clock: update the model from the current inputs, then compare.
  task automatic cycle();
    int  idx;
    bit  tk;
    if (bus.redirect_valid) begin
      exp_pc = bus.redirect_pc; exp_pt = 1'b0; exp_rm = 1'b0; pt_known = 1'b1;
      exp_q.delete();
      if (exp_mis < (1 << CNT_W) - 1) exp_mis++;
    end else if (bus.f_stall) begin
      // everything held
    end else if (!bus.f_valid) begin
      exp_pc = bus.f_valP; exp_rm = 1'b0; pt_known = 1'b0;
    end else begin
      exp_rm = 1'b0; pt_known = 1'b0; exp_pc = bus.f_valP;
      if (bus.f_icode == 4'd7) begin
        idx = int'(bus.f_pc % BHT_DEPTH);
        tk  = (bus.f_ifun == 4'd0) || (bht_m[idx] >= 2);
        exp_pc = tk ? bus.f_valC : bus.f_valP;
        exp_pt = tk; pt_known = 1'b1;
      end else if (bus.f_icode == 4'd8) begin
        exp_pc = bus.f_valC;
        exp_q.push_back(bus.f_valP);
        if (exp_q.size() > RAS_DEPTH) void'(exp_q.pop_front());
      end else if (bus.f_icode == 4'd9) begin
        if (exp_q.size() > 0) exp_pc = exp_q.pop_back();
        else exp_rm = 1'b1;
      end else begin
        exp_pt = 1'b0; pt_known = 1'b1;
      end
    end
    if (bus.e_bupd_valid) begin
      idx = int'(bus.e_bupd_pc % BHT_DEPTH);
      if (bus.e_bupd_taken && bht_m[idx] < 3) bht_m[idx]++;
      else if (!bus.e_bupd_taken && bht_m[idx] > 0) bht_m[idx]--;
    end
    @(posedge clock);
    #1;
    check("pc_pred", 64'(bus.pc_pred), 64'(exp_pc));
    check("ras_count", 64'(bus.ras_count), 64'(exp_q.size()));
    check("ret_miss", 64'(bus.ret_miss), 64'(exp_rm));
    check("mispredict_cnt", 64'(bus.mispredict_cnt), 64'(exp_mis));
    if (pt_known) check("pred_taken", 64'(bus.pred_taken), 64'(exp_pt));
  endtask

  logic [ADDR_W-1:0] held_pc;
  int r;

  initial begin
    idle();
    model_reset();
    #12;
    check("reset_pc", 64'(bus.pc_pred), 64'(RESET_PC));
    check("reset_pt", 64'(bus.pred_taken), 64'h0);
    check("reset_rm", 64'(bus.ret_miss), 64'h0);
    check("reset_ras", 64'(bus.ras_count), 64'h0);
    check("reset_mis", 64'(bus.mispredict_cnt), 64'h0);
    @(posedge clock); #1;
    reset = 1'b0;

    // async reset mid-run: train idx 0 taken, jump to 0x40, then reset between edges
    idle(); fetch(4'h7, 4'h0, 'h0, 'h40, 'h9);
    bus.e_bupd_valid = 1'b1; bus.e_bupd_pc = 'h10; bus.e_bupd_taken = 1'b1;
    cycle();
    idle(); bus.e_bupd_valid = 1'b1; bus.e_bupd_pc = 'h10; bus.e_bupd_taken = 1'b1;
    bus.f_valid = 1'b0; bus.f_stall = 1'b1;
    cycle();
    check("pre_reset_pc", 64'(bus.pc_pred), 64'h40);
    #2 reset = 1'b1;
    #1;
    check("async_reset_pc", 64'(bus.pc_pred), 64'h0);
    model_reset();
    @(posedge clock); #1;
    reset = 1'b0;
    idle(); fetch(4'h7, 4'h1, 'h10, 'h80, 'h19);
    cycle();
    check("bht_reset_wnt_pc", 64'(bus.pc_pred), 64'h19);
    check("bht_reset_wnt_pt", 64'(bus.pred_taken), 64'h0);

    // conditional jump trained taken by two updates
    idle(); bus.e_bupd_valid = 1'b1; bus.e_bupd_pc = 'h10; bus.e_bupd_taken = 1'b1;
    cycle(); cycle();
    idle(); fetch(4'h7, 4'h1, 'h10, 'h80, 'h19);
    cycle();
    check("jxx_trained_pc", 64'(bus.pc_pred), 64'h80);
    check("jxx_trained_pt", 64'(bus.pred_taken), 64'h1);

    // call / ret pair, then ret on empty stack
    idle(); fetch(4'h8, 4'h0, 'h20, 'h100, 'h29);
    cycle();
    check("call_pc", 64'(bus.pc_pred), 64'h100);
    check("call_ras", 64'(bus.ras_count), 64'h1);
    idle(); fetch(4'h9, 4'h0, 'h100, 'h0, 'h101);
    cycle();
    check("ret_pc", 64'(bus.pc_pred), 64'h29);
    check("ret_ras", 64'(bus.ras_count), 64'h0);
    idle(); fetch(4'h9, 4'h0, 'h30, 'h0, 'h31);
    cycle();
    check("ret_empty_miss", 64'(bus.ret_miss), 64'h1);
    check("ret_empty_pc", 64'(bus.pc_pred), 64'h31);

    // overflow: 9 calls, 9 rets
    for (int i = 1; i <= RAS_DEPTH + 1; i++) begin
      idle(); fetch(4'h8, 4'h0, 'h200 + i, 'h300, i);
      cycle();
    end
    check("ras_full", 64'(bus.ras_count), 64'(RAS_DEPTH));
    for (int i = RAS_DEPTH + 1; i >= 2; i--) begin
      idle(); fetch(4'h9, 4'h0, 'h400, 'h0, 'h401);
      cycle();
      check("ras_pop_val", 64'(bus.pc_pred), 64'(i));
    end
    idle(); fetch(4'h9, 4'h0, 'h400, 'h0, 'h401);
    cycle();
    check("ras_drained_miss", 64'(bus.ret_miss), 64'h1);

    // stall holds PC and RAS; redirect during stall wins
    idle(); fetch(4'h8, 4'h0, 'h50, 'h500, 'h59);
    cycle();
    held_pc = bus.pc_pred;
    for (int i = 0; i < 3; i++) begin
      idle(); fetch(4'h8, 4'h0, 'h60 + i, 'h600 + i, 'h70 + i);
      bus.f_stall = 1'b1;
      cycle();
      check("stall_pc_hold", 64'(bus.pc_pred), 64'(held_pc));
      check("stall_ras_hold", 64'(bus.ras_count), 64'h1);
    end
    bus.redirect_valid = 1'b1; bus.redirect_pc = 'h200;
    cycle();
    check("redirect_pc", 64'(bus.pc_pred), 64'h200);
    check("redirect_ras_clear", 64'(bus.ras_count), 64'h0);
    check("redirect_cnt", 64'(bus.mispredict_cnt), 64'h1);

    // same-cycle read and update: read sees old counter
    idle(); bus.e_bupd_valid = 1'b1; bus.e_bupd_pc = 'h34; bus.e_bupd_taken = 1'b1;
    cycle();
    idle(); fetch(4'h7, 4'h2, 'h34, 'h90, 'h3d);
    bus.e_bupd_valid = 1'b1; bus.e_bupd_pc = 'h34; bus.e_bupd_taken = 1'b0;
    cycle();
    check("rw_same_old_pt", 64'(bus.pred_taken), 64'h1);
    idle(); fetch(4'h7, 4'h2, 'h34, 'h90, 'h3d);
    cycle();
    check("rw_same_new_pt", 64'(bus.pred_taken), 64'h0);
    check("rw_same_new_pc", 64'(bus.pc_pred), 64'h3d);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      idle();
      r = $urandom_range(0, 99);
      if (r < 45)      bus.f_icode = 4'h7;
      else if (r < 62) bus.f_icode = 4'h8;
      else if (r < 80) bus.f_icode = 4'h9;
      else             bus.f_icode = 4'($urandom_range(0, 15));
      bus.f_ifun         = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom_range(1, 6));
      bus.f_valid        = ($urandom_range(0, 9) != 0);
      bus.f_stall        = ($urandom_range(0, 9) == 0);
      bus.f_pc           = ADDR_W'($urandom_range(0, 255));
      bus.f_valC         = ADDR_W'($urandom);
      bus.f_valP         = ADDR_W'($urandom);
      bus.e_bupd_valid   = ($urandom_range(0, 9) < 5);
      bus.e_bupd_pc      = ADDR_W'($urandom_range(0, 255));
      bus.e_bupd_taken   = 1'($urandom_range(0, 1));
      bus.redirect_valid = ($urandom_range(0, 39) == 0);
      bus.redirect_pc    = ADDR_W'($urandom);
      cycle();
    end

    // mispredict counter saturation
    for (int i = 0; i < (1 << CNT_W) + 2; i++) begin
      idle(); bus.redirect_valid = 1'b1; bus.redirect_pc = ADDR_W'(i);
      cycle();
    end
    check("mis_saturated", 64'(bus.mispredict_cnt), 64'((1 << CNT_W) - 1));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
